trace_sync_ctrl: RTL and testbench

- Controller for the traceIF capture datapath. Owns the traceIF `width` configuration.
- Hunts for TPIU sync, either at a fixed width or by auto-scanning widths 4/2/1 bits.
- Once synced, tracks 16-byte frame alignment from traceIF's `dvalid`/`sync` outputs.
- Declares loss of sync and counts misaligned syncs.
- Sits between traceIF and the downstream frame demultiplexer, in the `clk` domain.

---
 rtl/trace_sync_ctrl_pkg.sv | 38 +++
 rtl/trace_sync_ctrl_timer.sv | 39 +++
 rtl/trace_sync_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_trace_sync_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_sync_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the traceIF sync controller:
//   - traceIF width encodings (bits-1 encoding)
//   - controller state enum
//   - next_width(): auto-scan order 4 -> 2 -> 1 -> 4 bits
//   - map_cfg_width(): folds the reserved encoding 2 onto 4-bit mode
// ---------------------------------------------------------------------------
package trace_pkg;

  localparam logic [1:0] TW_1BIT = 2'd0;
  localparam logic [1:0] TW_2BIT = 2'd1;
  localparam logic [1:0] TW_4BIT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HUNT   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  // Auto-scan walks from the widest port downwards and wraps around.
  function automatic logic [1:0] next_width(input logic [1:0] w);
    logic [1:0] nw;
    case (w)
      TW_4BIT: nw = TW_2BIT;
      TW_2BIT: nw = TW_1BIT;
      default: nw = TW_4BIT;
    endcase
    return nw;
  endfunction

  // Encoding 2 (3 bits) is not a legal TPIU port width; run it as 4 bits.
  function automatic logic [1:0] map_cfg_width(input logic [1:0] cfg);
    return (cfg == 2'd2) ? TW_4BIT : cfg;
  endfunction

endpackage

// File: rtl/trace_sync_ctrl_timer.sv
// ---------------------------------------------------------------------------
// trace_timer
// Loadable down-counter with a zero flag. Loading has priority over
// decrementing; the count never wraps below zero.
// Ports:
//   clk, nRst  : clock, async active-low reset (count resets to 0)
//   load       : load load_val on the next edge
//   load_val   : value to load
//   dec        : decrement by one (ignored when already zero)
//   zero       : count == 0
// ---------------------------------------------------------------------------
module trace_timer
  import trace_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/trace_sync_ctrl.sv
// ---------------------------------------------------------------------------
// trace_sync_ctrl
// Sync/alignment controller for the traceIF capture path. Selects the
// traceIF port width (fixed or auto-scanned), hunts for TPIU sync, then
// tracks 16-byte frame alignment and reports misaligned syncs / sync loss.
// Ports:
//   clk, nRst   : clock, async active-low reset
//   autoEn      : 1 = auto-scan widths, 0 = fixed width from cfgWidth
//   cfgWidth    : fixed width, encoded bits-1 (2 is treated as 3)
//   clrErr      : synchronous clear of errCnt
//   dvalid      : byte strobe from traceIF
//   dIn         : byte from traceIF (not used here)
//   sync        : sync-detected pulse from traceIF
//   width       : width configuration to traceIF
//   locked      : frame alignment valid
//   frameStart  : pulse in the cycle after a frame's first byte
//   byteIdx     : byte index within the frame
//   lost        : one-cycle pulse on sync loss
//   errCnt      : saturating count of misaligned syncs
// ---------------------------------------------------------------------------
module trace_sync_ctrl
  import trace_pkg::*;
#(
  parameter int SETTLE_CYCLES = 32,
  parameter int SYNC_TIMEOUT  = 65536,
  parameter int LOSS_TIMEOUT  = 1048576,
  parameter int FRAME_BYTES   = 16
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       autoEn,
  input  logic [1:0] cfgWidth,
  input  logic       clrErr,
  input  logic       dvalid,
  input  logic [7:0] dIn,
  input  logic       sync,
  output logic [1:0] width,
  output logic       locked,
  output logic       frameStart,
  output logic [3:0] byteIdx,
  output logic       lost,
  output logic [7:0] errCnt
);

  localparam int MAX_A  = (SYNC_TIMEOUT > LOSS_TIMEOUT) ? SYNC_TIMEOUT : LOSS_TIMEOUT;
  localparam int MAX_TO = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
  localparam int TMR_W  = (MAX_TO > 1) ? $clog2(MAX_TO) : 1;

  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SYNC_LOAD   = TMR_W'(SYNC_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LOSS_LOAD   = TMR_W'(LOSS_TIMEOUT - 1);
  localparam logic [3:0]       LAST_IDX    = 4'(FRAME_BYTES - 1);

  // dIn is carried on the port for interface symmetry only.
  logic unused_din;
  assign unused_din = ^dIn;

  state_t           state_q, state_d;
  logic [1:0]       width_q, width_d;
  logic             locked_q, locked_d;
  logic             frame_start_q, frame_start_d;
  logic [3:0]       byte_idx_q, byte_idx_d;
  logic             lost_q, lost_d;
  logic [7:0]       err_cnt_q;
  logic             err_inc;
  logic             auto_q;
  logic [1:0]       cfg_q;
  logic             cfg_change;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_val;
  logic             tmr_dec;
  logic             tmr_zero;

  trace_timer #(
    .WIDTH(TMR_W)
  ) u_timer (
    .clk      (clk),
    .nRst     (nRst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // IDLE samples the live config itself, so a change is only acted on
  // once the controller has left IDLE; this keeps IDLE to a single cycle.
  assign cfg_change = (state_q != IDLE) &&
                      ((autoEn != auto_q) || (cfgWidth != cfg_q));

  // Next-state and next-output logic. Everything is computed here and
  // registered below so all outputs come straight from flops.
  always_comb begin
    state_d       = state_q;
    width_d       = width_q;
    locked_d      = 1'b0;
    frame_start_d = 1'b0;
    byte_idx_d    = 4'd0;
    lost_d        = 1'b0;
    err_inc       = 1'b0;
    tmr_load      = 1'b0;
    tmr_load_val  = SETTLE_LOAD;
    tmr_dec       = 1'b0;

    case (state_q)
      IDLE: begin
        width_d      = autoEn ? TW_4BIT : map_cfg_width(cfgWidth);
        tmr_load     = 1'b1;
        tmr_load_val = SETTLE_LOAD;
        state_d      = SETTLE;
      end

      SETTLE: begin
        if (tmr_zero) begin
          tmr_load     = 1'b1;
          tmr_load_val = SYNC_LOAD;
          state_d      = HUNT;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      HUNT: begin
        if (sync) begin
          locked_d     = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = LOSS_LOAD;
          state_d      = LOCKED;
        end else if (tmr_zero) begin
          tmr_load = 1'b1;
          if (auto_q) begin
            width_d      = next_width(width_q);
            tmr_load_val = SETTLE_LOAD;
            state_d      = SETTLE;
          end else begin
            tmr_load_val = SYNC_LOAD;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end

      LOCKED: begin
        locked_d   = 1'b1;
        byte_idx_d = byte_idx_q;
        if (dvalid) begin
          byte_idx_d    = (byte_idx_q == LAST_IDX) ? 4'd0 : byte_idx_q + 4'd1;
          frame_start_d = (byte_idx_q == 4'd0);
        end
        // A sync realigns the frame even if a byte arrived in the same
        // cycle; that byte still belongs to the old frame.
        if (sync) begin
          err_inc      = (byte_idx_q != 4'd0);
          byte_idx_d   = 4'd0;
          tmr_load     = 1'b1;
          tmr_load_val = LOSS_LOAD;
        end else if (tmr_zero) begin
          lost_d        = 1'b1;
          locked_d      = 1'b0;
          frame_start_d = 1'b0;
          byte_idx_d    = 4'd0;
          tmr_load      = 1'b1;
          tmr_load_val  = SYNC_LOAD;
          state_d       = HUNT;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A config change abandons whatever the FSM was doing.
    if (cfg_change) begin
      state_d       = IDLE;
      width_d       = width_q;
      locked_d      = 1'b0;
      frame_start_d = 1'b0;
      byte_idx_d    = 4'd0;
      lost_d        = 1'b0;
      err_inc       = 1'b0;
      tmr_load      = 1'b0;
      tmr_dec       = 1'b0;
    end
  end

  // State, config sample and output registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q       <= IDLE;
      width_q       <= TW_4BIT;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      byte_idx_q    <= 4'd0;
      lost_q        <= 1'b0;
      auto_q        <= 1'b0;
      cfg_q         <= 2'd0;
    end else begin
      state_q       <= state_d;
      width_q       <= width_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
      byte_idx_q    <= byte_idx_d;
      lost_q        <= lost_d;
      auto_q        <= autoEn;
      cfg_q         <= cfgWidth;
    end
  end

  // Error counter: clear beats increment, saturates at 255.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      err_cnt_q <= 8'd0;
    end else if (clrErr) begin
      err_cnt_q <= 8'd0;
    end else if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign width      = width_q;
  assign locked     = locked_q;
  assign frameStart = frame_start_q;
  assign byteIdx    = byte_idx_q;
  assign lost       = lost_q;
  assign errCnt     = err_cnt_q;

endmodule

// File: tb/tb_trace_sync_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trace_sync_ctrl
// Self-checking bench for trace_sync_ctrl with shortened timeouts. Every
// cycle the outputs are compared against a phase/age reference model.
// ---------------------------------------------------------------------------
module tb_trace_sync_ctrl;

  localparam int SETTLE  = 8;
  localparam int SYNC_TO = 64;
  localparam int LOSS_TO = 128;
  localparam int FB      = 16;

  localparam int P_IDLE   = 0;
  localparam int P_SETTLE = 1;
  localparam int P_HUNT   = 2;
  localparam int P_LOCKED = 3;

  logic       clk = 1'b0;
  logic       nRst;
  logic       autoEn;
  logic [1:0] cfgWidth;
  logic       clrErr;
  logic       dvalid;
  logic [7:0] dIn;
  logic       sync;
  logic [1:0] width;
  logic       locked;
  logic       frameStart;
  logic [3:0] byteIdx;
  logic       lost;
  logic [7:0] errCnt;

  int errors = 0;
  int checks = 0;

  // Reference model: phase plus cycles spent in that phase.
  int mPhase, mAge, mWidth, mLocked, mFs, mIdx, mLost, mErr, mAuto, mCfg, mScan;
  int scanOrder[3] = '{3, 1, 0};

  always #5 clk = ~clk;

  trace_sync_ctrl #(
    .SETTLE_CYCLES (SETTLE),
    .SYNC_TIMEOUT  (SYNC_TO),
    .LOSS_TIMEOUT  (LOSS_TO),
    .FRAME_BYTES   (FB)
  ) dut (
    .clk        (clk),
    .nRst       (nRst),
    .autoEn     (autoEn),
    .cfgWidth   (cfgWidth),
    .clrErr     (clrErr),
    .dvalid     (dvalid),
    .dIn        (dIn),
    .sync       (sync),
    .width      (width),
    .locked     (locked),
    .frameStart (frameStart),
    .byteIdx    (byteIdx),
    .lost       (lost),
    .errCnt     (errCnt)
  );

  task automatic modelReset();
    mPhase = P_IDLE; mAge = 0; mWidth = 3; mLocked = 0; mFs = 0;
    mIdx = 0; mLost = 0; mErr = 0; mAuto = 0; mCfg = 0; mScan = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs present at it.
  task automatic modelStep(input bit dv, input bit sy, input bit clr);
    bit changed;
    int oldIdx;
    changed = (mPhase != P_IDLE) && ((int'(autoEn) != mAuto) || (int'(cfgWidth) != mCfg));
    mFs = 0;
    mLost = 0;
    if (changed) begin
      mPhase = P_IDLE; mLocked = 0; mIdx = 0;
    end else if (mPhase == P_IDLE) begin
      if (autoEn) begin
        mScan = 0;
        mWidth = scanOrder[0];
      end else begin
        mWidth = (cfgWidth == 2'd2) ? 3 : int'(cfgWidth);
      end
      mPhase = P_SETTLE; mAge = 0;
    end else if (mPhase == P_SETTLE) begin
      mAge++;
      if (mAge == SETTLE) begin
        mPhase = P_HUNT; mAge = 0;
      end
    end else if (mPhase == P_HUNT) begin
      if (sy) begin
        mPhase = P_LOCKED; mLocked = 1; mIdx = 0; mAge = 0;
      end else begin
        mAge++;
        if (mAge == SYNC_TO) begin
          mAge = 0;
          if (mAuto != 0) begin
            mScan = (mScan + 1) % 3;
            mWidth = scanOrder[mScan];
            mPhase = P_SETTLE;
          end
        end
      end
    end else begin
      oldIdx = mIdx;
      if (dv) begin
        mFs = (oldIdx == 0) ? 1 : 0;
        mIdx = (oldIdx + 1) % FB;
      end
      if (sy) begin
        if (oldIdx != 0 && mErr < 255) mErr++;
        mIdx = 0;
        mAge = 0;
      end else begin
        mAge++;
        if (mAge == LOSS_TO) begin
          mLost = 1; mLocked = 0; mIdx = 0; mFs = 0;
          mPhase = P_HUNT; mAge = 0;
        end
      end
    end
    if (clr) mErr = 0;
    mAuto = int'(autoEn);
    mCfg = int'(cfgWidth);
  endtask

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkOne({tag, ".width"},      32'(width),      32'(mWidth));
    checkOne({tag, ".locked"},     32'(locked),     32'(mLocked));
    checkOne({tag, ".frameStart"}, 32'(frameStart), 32'(mFs));
    checkOne({tag, ".byteIdx"},    32'(byteIdx),    32'(mIdx));
    checkOne({tag, ".lost"},       32'(lost),       32'(mLost));
    checkOne({tag, ".errCnt"},     32'(errCnt),     32'(mErr));
  endtask

  // Drive one cycle of inputs, advance one edge, then check all outputs.
  task automatic applyStimulus(input bit dv, input bit sy, input bit clr, input string tag);
    dvalid = dv;
    sync   = sy;
    clrErr = clr;
    dIn    = 8'($urandom);
    @(posedge clk);
    modelStep(dv, sy, clr);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    int lostCount;
    int lostStep;
    int found;
    int widthChanges;
    logic [1:0] prevWidth;

    nRst = 1'b0; autoEn = 1'b0; cfgWidth = 2'd1;
    clrErr = 1'b0; dvalid = 1'b0; sync = 1'b0; dIn = 8'd0;
    modelReset();
    #12;
    checkOutput("reset");
    nRst = 1'b1;

    // Manual lock at width 1 (2 bits); a sync during SETTLE must be ignored.
    repeat (3) applyStimulus(0, 0, 0, "manual_settle");
    applyStimulus(0, 1, 0, "settle_mask");
    checkOne("settle_mask_unlocked", 32'(locked), 32'd0);
    repeat (15) applyStimulus(0, 0, 0, "manual_hunt");
    applyStimulus(0, 1, 0, "manual_lock");
    checkOne("manual_lock_locked", 32'(locked), 32'd1);
    checkOne("manual_lock_width", 32'(width), 32'd1);

    // Frame counting with randomized gaps between bytes.
    for (int i = 0; i < 34; i++) begin
      int gap;
      gap = $urandom_range(0, 1);
      for (int g = 0; g < gap; g++) applyStimulus(0, 0, 0, "frame_gap");
      applyStimulus(1, 0, 0, "frame_dv");
    end
    checkOne("frame_idx_after34", 32'(byteIdx), 32'd2);
    repeat (13) applyStimulus(1, 0, 0, "frame_fill");
    applyStimulus(1, 1, 0, "dv_sync_at15");
    checkOne("dv_sync_idx", 32'(byteIdx), 32'd0);
    checkOne("dv_sync_err", 32'(errCnt), 32'd1);

    // Misaligned syncs up to saturation, then clear racing an increment.
    repeat (5) applyStimulus(1, 0, 0, "err_dv");
    applyStimulus(0, 1, 0, "err_sync5");
    checkOne("err_after_sync5", 32'(errCnt), 32'd2);
    for (int i = 0; i < 300; i++) begin
      int k;
      k = $urandom_range(1, 15);
      for (int j = 0; j < k; j++) applyStimulus(1, 0, 0, "sat_dv");
      applyStimulus(0, 1, 0, "sat_sync");
    end
    checkOne("err_saturated", 32'(errCnt), 32'd255);
    repeat (3) applyStimulus(1, 0, 0, "clr_dv");
    applyStimulus(0, 1, 1, "clr_vs_inc");
    checkOne("err_cleared", 32'(errCnt), 32'd0);

    // Random traffic while locked.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 63) == 0), "random_locked");
    end

    // Loss of sync: lost must pulse exactly once, 128 cycles after the last sync.
    applyStimulus(0, 1, 0, "pre_loss_sync");
    lostCount = 0;
    lostStep = 0;
    for (int i = 1; i <= 130; i++) begin
      applyStimulus(0, 0, 0, "loss_wait");
      if (lost === 1'b1) begin
        lostCount++;
        lostStep = i;
      end
    end
    checkOne("lost_pulse_count", 32'(lostCount), 32'd1);
    checkOne("lost_pulse_cycle", 32'(lostStep), 32'(LOSS_TO));
    checkOne("lost_width_kept", 32'(width), 32'd1);

    // Manual HUNT timeout reloads and keeps the width; then relock.
    repeat (70) applyStimulus(0, 0, 0, "manual_rehunt");
    applyStimulus(0, 1, 0, "relock");

    // Config change while locked drops lock; reserved encoding runs as 4 bits.
    cfgWidth = 2'd2;
    repeat (12) applyStimulus(1, 0, 0, "cfg_change");
    checkOne("cfg_change_width", 32'(width), 32'd3);
    checkOne("cfg_change_unlocked", 32'(locked), 32'd0);

    // Auto scan with no sync: expect width to step through 3,1,0,3.
    autoEn = 1'b1;
    widthChanges = 0;
    prevWidth = width;
    for (int i = 0; i < 240; i++) begin
      applyStimulus(0, 0, 0, "auto_scan");
      if (width !== prevWidth) widthChanges++;
      prevWidth = width;
    end
    checkOne("auto_scan_changes", 32'(widthChanges), 32'd3);

    // Wait for the 2-bit hunt window and sync there.
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      if (mWidth == 1 && mPhase == P_HUNT) found = 1;
      else applyStimulus(0, 0, 0, "auto_wait");
    end
    checkOne("auto_wait_reached", 32'(found), 32'd1);
    applyStimulus(0, 1, 0, "auto_lock");
    checkOne("auto_lock_width", 32'(width), 32'd1);
    repeat (7) applyStimulus(1, 0, 0, "auto_frame");

    // Asynchronous reset mid-frame, away from any clock edge.
    #2 nRst = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset");
    #1 nRst = 1'b1;
    repeat (12) applyStimulus(1'($urandom_range(0, 1)), 0, 0, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
